// File: rtl/nibble_adder_pkg.sv
// ---------------------------------------------------------------------------
// nibble_adder_pkg
// Shared definitions for the nibble-serial adder controller.
//   nsa_state_t : controller FSM state encoding (IDLE, RUN, DONE)
//   NIBBLE_W    : width of the shared adder cell, in bits
// ---------------------------------------------------------------------------
package nibble_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

    localparam int NIBBLE_W = 4;

endpackage : nibble_adder_pkg

// File: rtl/four_bit_full_adder.sv
// ---------------------------------------------------------------------------
// four_bit_full_adder
// Purely combinational 4-bit ripple-carry adder cell.
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry into bit 0
//   sum   : 4-bit sum
//   cout  : carry out of bit 3
// ---------------------------------------------------------------------------
module four_bit_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // w_carry[k] is the carry into bit k; w_carry[4] leaves the cell.
    logic [4:0] w_carry;

    assign w_carry[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[4];

endmodule : four_bit_full_adder

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands using a single shared 4-bit adder cell, one
// nibble per clock, least-significant nibble first. The carry between
// nibbles is held in a register. Operands arrive on a valid/ready handshake
// and the result leaves on a second valid/ready handshake.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   in_valid   : a/b/cin are valid
//   in_ready   : controller is idle and will accept operands
//   a, b       : WIDTH-bit operands
//   cin        : carry into nibble 0
//   out_valid  : sum/cout hold a finished result
//   out_ready  : consumer accepts the result
//   sum        : registered WIDTH-bit sum
//   cout       : registered final carry-out
//   busy       : an operation is running or waiting to be collected
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
            $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    nsa_state_t          r_state;
    nsa_state_t          w_state_next;
    logic [CNT_W-1:0]    r_idx;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic                r_cout;

    // ---------------------------------------------------------------------
    // Nibble views of the latched operands, selected by the nibble index
    // ---------------------------------------------------------------------
    logic [NIBBLE_W-1:0] w_a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] w_b_nib [NIBBLES];

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_a_nib[gi] = r_a[gi*NIBBLE_W +: NIBBLE_W];
            assign w_b_nib[gi] = r_b[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    logic [NIBBLE_W-1:0] w_add_a;
    logic [NIBBLE_W-1:0] w_add_b;
    logic [NIBBLE_W-1:0] w_add_sum;
    logic                w_add_cout;
    logic                w_last;

    assign w_add_a = w_a_nib[r_idx];
    assign w_add_b = w_b_nib[r_idx];

    // With a single nibble the index is always 0, so this is constant true.
    assign w_last  = (r_idx == CNT_W'(NIBBLES - 1));

    four_bit_full_adder u_adder (
        .a    (w_add_a),
        .b    (w_add_b),
        .cin  (r_carry),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs. Both handshake outputs depend
    // only on the registered state (and rst), never on the peer's signal.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: operand capture, per-nibble sum write-back, carry ripple
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready is high whenever rst is low in IDLE
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    // Only the current nibble is written; the others keep
                    // whatever they held until their turn comes.
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (r_idx == CNT_W'(i)) begin
                            r_sum[i*NIBBLE_W +: NIBBLE_W] <= w_add_sum;
                        end
                    end
                    r_carry <= w_add_cout;
                    if (w_last) begin
                        r_cout <= w_add_cout;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + 1'b1;
                    end
                end
                default: begin
                    // DONE: result registers hold their value
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule : nibble_serial_adder_ctrl

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed bench for the nibble-serial adder controller: a 16-bit instance
// for the main scenarios and a 4-bit instance for the single-nibble build.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst;

    // 16-bit instance
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;

    // 4-bit instance
    logic        in_valid_4;
    logic        in_ready_4;
    logic [3:0]  a_4;
    logic [3:0]  b_4;
    logic        cin_4;
    logic        out_valid_4;
    logic        out_ready_4;
    logic [3:0]  sum_4;
    logic        cout_4;
    logic        busy_4;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    nibble_serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid_4),
        .in_ready  (in_ready_4),
        .a         (a_4),
        .b         (b_4),
        .cin       (cin_4),
        .out_valid (out_valid_4),
        .out_ready (out_ready_4),
        .sum       (sum_4),
        .cout      (cout_4),
        .busy      (busy_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operand set on the 16-bit instance and let it be taken at the
    // next rising edge. Returns at the following falling edge with the
    // operand inputs scrambled, and reports in_ready as seen at the edge.
    task automatic start_op(input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, output logic rdy);
        @(negedge clk);
        a        = xa;
        b        = xb;
        cin      = xc;
        in_valid = 1'b1;
        rdy      = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        cin      = 1'b1;
    endtask

    // Count falling edges until out_valid is seen; -1 if it never comes.
    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (out_valid !== 1'b1) n = -1;
    endtask

    // Collect a pending result with a one-cycle out_ready pulse.
    task automatic collect;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, busy, cout, sum} !== 20'h0) begin
            failures++;
            $display("FAIL reset_state16: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want all 0",
                     in_ready, out_valid, busy, cout, sum);
        end
        checks++;
        if ({in_ready_4, out_valid_4, busy_4, cout_4, sum_4} !== 8'h0) begin
            failures++;
            $display("FAIL reset_state4: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want all 0",
                     in_ready_4, out_valid_4, busy_4, cout_4, sum_4);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || in_ready_4 !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b/%b, want 1/1", in_ready, in_ready_4);
        end
        $display("test_reset done");
    endtask

    task automatic test_carry_chain;
        logic rdy;
        int   n;
        logic bad;
        out_ready = 1'b1;
        start_op(16'hFFFF, 16'h0001, 1'b0, rdy);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL carry_accept_ready: got %b, want 1", rdy);
        end
        n   = 0;
        bad = 1'b0;
        while (out_valid !== 1'b1 && n < 20) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL carry_latency: got %0d cycles, want 4", n);
        end
        checks++;
        if ({cout, sum} !== 17'h1_0000) begin
            failures++;
            $display("FAIL carry_result: got cout=%b sum=%h, want cout=1 sum=0000", cout, sum);
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL carry_ready_busy_in_run: in_ready high or busy low during RUN/DONE");
        end
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL carry_release: got vld=%b rdy=%b, want vld=0 rdy=1", out_valid, in_ready);
        end
        $display("test_carry_chain: FFFF+0001+0 -> cout=%b sum=%h latency=%0d", cout, sum, n);
    endtask

    task automatic test_basic;
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic        vc [2];
        logic [16:0] exp_r [2];
        logic        rdy;
        int          n;
        va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b1; exp_r[0] = 17'h0_5556;
        va[1] = 16'h8000; vb[1] = 16'h8000; vc[1] = 1'b0; exp_r[1] = 17'h1_0000;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_op(va[i], vb[i], vc[i], rdy);
            wait_valid(n);
            checks++;
            if (n != 4 || rdy !== 1'b1) begin
                failures++;
                $display("FAIL basic_latency[%0d]: got %0d cycles rdy=%b, want 4 rdy=1", i, n, rdy);
            end
            checks++;
            if ({cout, sum} !== exp_r[i]) begin
                failures++;
                $display("FAIL basic_result[%0d]: got %h, want %h", i, {cout, sum}, exp_r[i]);
            end
            $display("test_basic[%0d]: %h+%h+%b -> cout=%b sum=%h", i, va[i], vb[i], vc[i], cout, sum);
            collect();
        end
    endtask

    task automatic test_backpressure;
        logic rdy;
        int   n;
        out_ready = 1'b0;
        start_op(16'h00FF, 16'h0001, 1'b0, rdy);
        wait_valid(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL bp_latency: got %0d cycles, want 4", n);
        end
        for (int k = 0; k < 6; k++) begin
            // operand-side activity while DONE must have no effect
            in_valid = 1'b1;
            a        = 16'h5A5A;
            b        = 16'hA5A5;
            @(negedge clk);
            checks++;
            if ({out_valid, busy, in_ready, cout, sum} !== {4'b1100, 16'h0100}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got vld=%b busy=%b rdy=%b cout=%b sum=%h, want 1 1 0 0 0100",
                         k, out_valid, busy, in_ready, cout, sum);
            end
        end
        in_valid = 1'b0;
        collect();
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL bp_single_handshake: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        $display("test_backpressure: 00FF+0001 held 6 cycles -> sum=%h", sum);
    endtask

    task automatic test_back_to_back;
        int          t1;
        int          t2;
        logic [16:0] s1;
        logic [16:0] s2;
        logic        ir5;
        logic        ir6;
        t1 = -1; t2 = -1; s1 = '0; s2 = '0; ir5 = 1'bx; ir6 = 1'bx;
        out_ready = 1'b1;
        @(negedge clk);
        a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFE; b = 16'h0001; cin = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (out_valid === 1'b1 && t1 < 0) begin
                t1 = n; s1 = {cout, sum};
            end else if (out_valid === 1'b1 && t1 >= 0 && n > t1 + 1 && t2 < 0) begin
                t2 = n; s2 = {cout, sum};
            end
            if (n == 5) ir5 = in_ready;
            if (n == 6) begin
                ir6      = in_ready;
                in_valid = 1'b0;
            end
            if (t2 >= 0) break;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (t1 != 4 || s1 !== 17'h0_0002) begin
            failures++;
            $display("FAIL b2b_op1: got t=%0d result=%h, want t=4 result=00002", t1, s1);
        end
        checks++;
        if (ir5 !== 1'b1 || ir6 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept_slot: got rdy@5=%b rdy@6=%b, want 1 0", ir5, ir6);
        end
        checks++;
        if (t2 != 10 || s2 !== 17'h1_0000) begin
            failures++;
            $display("FAIL b2b_op2: got t=%0d result=%h, want t=10 result=10000", t2, s2);
        end
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_back_to_back: op1 %h @%0d, op2 %h @%0d", s1, t1, s2, t2);
    endtask

    task automatic test_reset_mid_run;
        logic rdy;
        int   n;
        logic stale;
        out_ready = 1'b0;
        start_op(16'h1111, 16'h2222, 1'b0, rdy);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sum !== 16'h0033 || busy !== 1'b1) begin
            failures++;
            $display("FAIL midrun_partial: got sum=%h busy=%b, want 0033 1", sum, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, busy, in_ready, cout, sum} !== 20'h0) begin
            failures++;
            $display("FAIL midrun_reset_clear: got vld=%b busy=%b rdy=%b cout=%b sum=%h, want all 0",
                     out_valid, busy, in_ready, cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrun_ready_after: got %b, want 1", in_ready);
        end
        stale = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL midrun_no_stale: out_valid or busy rose after reset, want both 0");
        end
        start_op(16'h0003, 16'h0004, 1'b0, rdy);
        wait_valid(n);
        checks++;
        if (n != 4 || {cout, sum} !== 17'h0_0007) begin
            failures++;
            $display("FAIL midrun_fresh_op: got t=%0d result=%h, want t=4 result=00007", n, {cout, sum});
        end
        collect();
        $display("test_reset_mid_run: fresh 0003+0004 -> sum=%h", sum);
    endtask

    task automatic test_width4;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       rc;
        logic [4:0] exp_r;
        int         n;
        out_ready_4 = 1'b1;
        @(negedge clk);
        a_4 = 4'hF; b_4 = 4'hF; cin_4 = 1'b1; in_valid_4 = 1'b1;
        checks++;
        if (in_ready_4 !== 1'b1) begin
            failures++;
            $display("FAIL w4_ready: got %b, want 1", in_ready_4);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_4 = 1'b0;
        checks++;
        if (out_valid_4 !== 1'b0 || busy_4 !== 1'b1) begin
            failures++;
            $display("FAIL w4_run: got vld=%b busy=%b, want 0 1", out_valid_4, busy_4);
        end
        @(negedge clk);
        checks++;
        if (out_valid_4 !== 1'b1 || {cout_4, sum_4} !== 5'h1F) begin
            failures++;
            $display("FAIL w4_result: got vld=%b result=%h, want 1 1f", out_valid_4, {cout_4, sum_4});
        end
        $display("test_width4: F+F+1 -> cout=%b sum=%h", cout_4, sum_4);
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            exp_r = {1'b0, ra} + {1'b0, rb} + {4'b0, rc};
            a_4 = ra; b_4 = rb; cin_4 = rc; in_valid_4 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            in_valid_4 = 1'b0;
            n = 0;
            while (out_valid_4 !== 1'b1 && n < 5) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n != 1 || {cout_4, sum_4} !== exp_r) begin
                failures++;
                $display("FAIL w4_rand[%0d]: %h+%h+%b got t=%0d result=%h, want t=1 result=%h",
                         i, ra, rb, rc, n, {cout_4, sum_4}, exp_r);
            end
            @(negedge clk);
        end
        out_ready_4 = 1'b0;
        $display("test_width4: 1000 random ops checked");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;
        out_ready   = 1'b0;
        in_valid_4  = 1'b0;
        a_4         = '0;
        b_4         = '0;
        cin_4       = 1'b0;
        out_ready_4 = 1'b0;

        test_reset();
        test_carry_chain();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_adder_ctrl
